// File: rtl/tcp_rx_notify_handler_pkg.sv
// lynxTypes: shared TCP notify/read types, receive FSM states and network bus constants
package lynxTypes;
  localparam int AXI_NET_BITS   = 512;
  localparam int BYTES_PER_BEAT = AXI_NET_BITS / 8;
  typedef struct packed {
    logic [15:0] sid;
    logic [15:0] len;
    logic [31:0] ip;
    logic [15:0] port;
    logic        closed;
  } tcp_notify_t;
  typedef struct packed {
    logic [15:0] sid;
    logic [15:0] len;
  } tcp_rd_pkg_t;
  typedef struct packed {
    logic [15:0] sid;
  } tcp_rx_meta_t;
  typedef enum logic [2:0] {IDLE, RD_REQ, META, DESC, DATA} rx_state_t;
endpackage

// File: rtl/tcp_rx_notify_handler_stats.sv
// tcp_rx_stats: wrapping 32-bit counters of completed transfers, forwarded beats and dropped notifies
// Ports: aclk/areset (async active-high), i_xfer/i_beat/i_drop event pulses, stat_* counter outputs.
module tcp_rx_stats (
  input  logic        aclk,
  input  logic        areset,
  input  logic        i_xfer,
  input  logic        i_beat,
  input  logic        i_drop,
  output logic [31:0] stat_xfers,
  output logic [31:0] stat_beats,
  output logic [31:0] stat_drops
);
  logic [31:0] r_xfers, r_beats, r_drops;
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_xfers <= '0;
      r_beats <= '0;
      r_drops <= '0;
    end else begin
      r_xfers <= r_xfers + 32'(i_xfer);
      r_beats <= r_beats + 32'(i_beat);
      r_drops <= r_drops + 32'(i_drop);
    end
  end
  assign stat_xfers = r_xfers;
  assign stat_beats = r_beats;
  assign stat_drops = r_drops;
endmodule

// File: rtl/tcp_rx_notify_handler.sv
// tcp_rx_notify_handler: turns TCP rx notifies into one read request, descriptor and counted payload burst at a time
// Ports: aclk/areset (async active-high); s_tcp_notify_* in; m_tcp_rd_pkg_* read request out;
// s_tcp_rx_meta_* returned sid in; s_axis_tcp_rx_* payload in; m_axis_rx_u_* payload out;
// m_rx_req_u_* descriptor out; sid_err sticky mismatch flag.
// Optional: define TCP_RX_STATS_EN to add stat_xfers/stat_beats/stat_drops counters.
module tcp_rx_notify_handler
  import lynxTypes::*;
#(
  parameter int N_BEAT_BITS = 11
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      s_tcp_notify_valid,
  output logic                      s_tcp_notify_ready,
  input  logic [15:0]               s_tcp_notify_sid,
  input  logic [15:0]               s_tcp_notify_len,
  input  logic [31:0]               s_tcp_notify_ip,
  input  logic [15:0]               s_tcp_notify_port,
  input  logic                      s_tcp_notify_closed,
  output logic                      m_tcp_rd_pkg_valid,
  input  logic                      m_tcp_rd_pkg_ready,
  output logic [15:0]               m_tcp_rd_pkg_sid,
  output logic [15:0]               m_tcp_rd_pkg_len,
  input  logic                      s_tcp_rx_meta_valid,
  output logic                      s_tcp_rx_meta_ready,
  input  logic [15:0]               s_tcp_rx_meta_sid,
  input  logic                      s_axis_tcp_rx_tvalid,
  output logic                      s_axis_tcp_rx_tready,
  input  logic [AXI_NET_BITS-1:0]   s_axis_tcp_rx_tdata,
  input  logic [AXI_NET_BITS/8-1:0] s_axis_tcp_rx_tkeep,
  input  logic                      s_axis_tcp_rx_tlast,
  output logic                      m_axis_rx_u_tvalid,
  input  logic                      m_axis_rx_u_tready,
  output logic [AXI_NET_BITS-1:0]   m_axis_rx_u_tdata,
  output logic [AXI_NET_BITS/8-1:0] m_axis_rx_u_tkeep,
  output logic                      m_axis_rx_u_tlast,
  output logic                      m_rx_req_u_valid,
  input  logic                      m_rx_req_u_ready,
  output logic [15:0]               m_rx_req_u_sid,
  output logic [15:0]               m_rx_req_u_len,
  output logic                      sid_err
`ifdef TCP_RX_STATS_EN
  ,
  output logic [31:0]               stat_xfers,
  output logic [31:0]               stat_beats,
  output logic [31:0]               stat_drops
`endif
);
  rx_state_t              r_state, w_next;
  tcp_rd_pkg_t            r_req;
  logic [N_BEAT_BITS-1:0] r_left;
  logic                   r_sid_err;
  logic [16:0]            w_sum;
  logic                   w_ntf_hs, w_accept, w_meta_hs, w_data, w_beat, w_last;
  logic                   w_unused;
  // ip/port are not needed to drain a session, and the burst length comes from len, not input tlast
  assign w_unused = ^{s_tcp_notify_ip, s_tcp_notify_port, s_axis_tcp_rx_tlast};
  assign w_sum     = {1'b0, s_tcp_notify_len} + 17'(BYTES_PER_BEAT - 1);
  assign w_ntf_hs  = s_tcp_notify_valid & s_tcp_notify_ready;
  assign w_accept  = w_ntf_hs & ~s_tcp_notify_closed & |s_tcp_notify_len;
  assign w_meta_hs = s_tcp_rx_meta_valid & s_tcp_rx_meta_ready;
  assign w_data    = r_state == DATA;
  assign w_beat    = m_axis_rx_u_tvalid & m_axis_rx_u_tready;
  assign w_last    = r_left == N_BEAT_BITS'(1);
  assign s_tcp_notify_ready  = (r_state == IDLE) & ~areset;
  assign m_tcp_rd_pkg_valid  = r_state == RD_REQ;
  assign s_tcp_rx_meta_ready = r_state == META;
  assign m_rx_req_u_valid    = r_state == DESC;
  assign {m_tcp_rd_pkg_sid, m_tcp_rd_pkg_len} = r_req;
  assign {m_rx_req_u_sid, m_rx_req_u_len}     = r_req;
  // payload path is a pure pass-through gated by the DATA state
  assign s_axis_tcp_rx_tready = w_data & m_axis_rx_u_tready;
  assign m_axis_rx_u_tvalid   = w_data & s_axis_tcp_rx_tvalid;
  assign m_axis_rx_u_tdata    = s_axis_tcp_rx_tdata;
  assign m_axis_rx_u_tkeep    = s_axis_tcp_rx_tkeep;
  assign m_axis_rx_u_tlast    = m_axis_rx_u_tvalid & w_last;
  assign sid_err              = r_sid_err;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? RD_REQ : IDLE;
      RD_REQ:  w_next = m_tcp_rd_pkg_ready ? META : RD_REQ;
      META:    w_next = s_tcp_rx_meta_valid ? DESC : META;
      DESC:    w_next = m_rx_req_u_ready ? DATA : DESC;
      DATA:    w_next = (w_beat & w_last) ? IDLE : DATA;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state   <= IDLE;
      r_req     <= '0;
      r_left    <= '0;
      r_sid_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_req  <= '{sid: s_tcp_notify_sid, len: s_tcp_notify_len};
        r_left <= N_BEAT_BITS'(w_sum >> $clog2(BYTES_PER_BEAT));
      end else if (w_beat) r_left <= r_left - N_BEAT_BITS'(1);
      if (w_meta_hs && s_tcp_rx_meta_sid != r_req.sid) r_sid_err <= 1'b1;
    end
  end
`ifdef TCP_RX_STATS_EN
  logic w_drop;
  assign w_drop = w_ntf_hs & ~w_accept;
  tcp_rx_stats u_stats (
    .aclk       (aclk),
    .areset     (areset),
    .i_xfer     (w_beat & w_last),
    .i_beat     (w_beat),
    .i_drop     (w_drop),
    .stat_xfers (stat_xfers),
    .stat_beats (stat_beats),
    .stat_drops (stat_drops)
  );
`endif
endmodule

// File: tb/tb_tcp_rx_notify_handler.sv
// tb_tcp_rx_notify_handler: directed and randomized checks of the notify-to-user receive path
module tb_tcp_rx_notify_handler;
  logic         aclk, areset;
  logic         s_tcp_notify_valid, s_tcp_notify_ready, s_tcp_notify_closed;
  logic [15:0]  s_tcp_notify_sid, s_tcp_notify_len, s_tcp_notify_port;
  logic [31:0]  s_tcp_notify_ip;
  logic         m_tcp_rd_pkg_valid, m_tcp_rd_pkg_ready;
  logic [15:0]  m_tcp_rd_pkg_sid, m_tcp_rd_pkg_len;
  logic         s_tcp_rx_meta_valid, s_tcp_rx_meta_ready;
  logic [15:0]  s_tcp_rx_meta_sid;
  logic         s_axis_tcp_rx_tvalid, s_axis_tcp_rx_tready, s_axis_tcp_rx_tlast;
  logic [511:0] s_axis_tcp_rx_tdata, m_axis_rx_u_tdata;
  logic [63:0]  s_axis_tcp_rx_tkeep, m_axis_rx_u_tkeep;
  logic         m_axis_rx_u_tvalid, m_axis_rx_u_tready, m_axis_rx_u_tlast;
  logic         m_rx_req_u_valid, m_rx_req_u_ready;
  logic [15:0]  m_rx_req_u_sid, m_rx_req_u_len;
  logic         sid_err;
`ifdef TCP_RX_STATS_EN
  logic [31:0]  stat_xfers, stat_beats, stat_drops;
`endif
  int n_assert = 0, n_fail = 0;
  bit exp_err = 0;
  int exp_xfers = 0, exp_beats = 0, exp_drops = 0;

  tcp_rx_notify_handler #(.N_BEAT_BITS(11)) dut (
    .aclk(aclk), .areset(areset),
    .s_tcp_notify_valid(s_tcp_notify_valid), .s_tcp_notify_ready(s_tcp_notify_ready),
    .s_tcp_notify_sid(s_tcp_notify_sid), .s_tcp_notify_len(s_tcp_notify_len),
    .s_tcp_notify_ip(s_tcp_notify_ip), .s_tcp_notify_port(s_tcp_notify_port),
    .s_tcp_notify_closed(s_tcp_notify_closed),
    .m_tcp_rd_pkg_valid(m_tcp_rd_pkg_valid), .m_tcp_rd_pkg_ready(m_tcp_rd_pkg_ready),
    .m_tcp_rd_pkg_sid(m_tcp_rd_pkg_sid), .m_tcp_rd_pkg_len(m_tcp_rd_pkg_len),
    .s_tcp_rx_meta_valid(s_tcp_rx_meta_valid), .s_tcp_rx_meta_ready(s_tcp_rx_meta_ready),
    .s_tcp_rx_meta_sid(s_tcp_rx_meta_sid),
    .s_axis_tcp_rx_tvalid(s_axis_tcp_rx_tvalid), .s_axis_tcp_rx_tready(s_axis_tcp_rx_tready),
    .s_axis_tcp_rx_tdata(s_axis_tcp_rx_tdata), .s_axis_tcp_rx_tkeep(s_axis_tcp_rx_tkeep),
    .s_axis_tcp_rx_tlast(s_axis_tcp_rx_tlast),
    .m_axis_rx_u_tvalid(m_axis_rx_u_tvalid), .m_axis_rx_u_tready(m_axis_rx_u_tready),
    .m_axis_rx_u_tdata(m_axis_rx_u_tdata), .m_axis_rx_u_tkeep(m_axis_rx_u_tkeep),
    .m_axis_rx_u_tlast(m_axis_rx_u_tlast),
    .m_rx_req_u_valid(m_rx_req_u_valid), .m_rx_req_u_ready(m_rx_req_u_ready),
    .m_rx_req_u_sid(m_rx_req_u_sid), .m_rx_req_u_len(m_rx_req_u_len),
    .sid_err(sid_err)
`ifdef TCP_RX_STATS_EN
    , .stat_xfers(stat_xfers), .stat_beats(stat_beats), .stat_drops(stat_drops)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nx;
    @(negedge aclk);
  endtask

  task automatic rnd(output logic [511:0] d, output logic [63:0] k);
    for (int j = 0; j < 16; j++) d[j*32+:32] = $urandom;
    k = {$urandom, $urandom};
  endtask

  // notify -> read request -> meta -> descriptor; ends on the negedge after entering DATA
  task automatic start_xfer(input logic [15:0] sid, input logic [15:0] len, input logic [15:0] msid);
    int nw;
    s_axis_tcp_rx_tvalid = 1'b1;
    m_axis_rx_u_tready = 1'b1;
    nx;
    s_tcp_notify_valid = 1'b1;
    s_tcp_notify_sid = sid;
    s_tcp_notify_len = len;
    s_tcp_notify_closed = 1'b0;
    s_tcp_notify_ip = $urandom;
    s_tcp_notify_port = 16'($urandom);
    #1;
    chk("ntf_ready_idle", s_tcp_notify_ready, 1);
    nx;
    s_tcp_notify_valid = 1'b0;
    nw = $urandom_range(0, 2);
    for (int w = 0; w <= nw; w++) begin
      #1;
      chk("rd_valid", m_tcp_rd_pkg_valid, 1);
      chk("rd_sid", m_tcp_rd_pkg_sid, sid);
      chk("rd_len", m_tcp_rd_pkg_len, len);
      chk("m_tvalid_ctrl", m_axis_rx_u_tvalid, 0);
      chk("s_tready_ctrl", s_axis_tcp_rx_tready, 0);
      if (w < nw) nx;
    end
    m_tcp_rd_pkg_ready = 1'b1;
    nx;
    m_tcp_rd_pkg_ready = 1'b0;
    #1;
    chk("meta_ready", s_tcp_rx_meta_ready, 1);
    chk("rd_valid_off", m_tcp_rd_pkg_valid, 0);
    s_tcp_rx_meta_valid = 1'b1;
    s_tcp_rx_meta_sid = msid;
    nx;
    s_tcp_rx_meta_valid = 1'b0;
    if (msid != sid) exp_err = 1'b1;
    nw = $urandom_range(0, 2);
    for (int w = 0; w <= nw; w++) begin
      #1;
      chk("desc_valid", m_rx_req_u_valid, 1);
      chk("desc_sid", m_rx_req_u_sid, sid);
      chk("desc_len", m_rx_req_u_len, len);
      chk("sid_err", sid_err, exp_err);
      if (w < nw) nx;
    end
    m_rx_req_u_ready = 1'b1;
    nx;
    m_rx_req_u_ready = 1'b0;
  endtask

  // mode 0: always ready; 1: sink ready toggles each cycle; 2: random valid and ready
  task automatic data_phase(input int beats, input int stop_after, input int tl_pos, input int mode);
    int i, cyc;
    logic [511:0] d;
    logic [63:0] k;
    i = 0;
    cyc = 0;
    rnd(d, k);
    while (i < stop_after && cyc < stop_after * 12 + 20) begin
      s_axis_tcp_rx_tvalid = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axis_rx_u_tready = (mode == 0) ? 1'b1 : (mode == 1) ? ~cyc[0] : 1'($urandom_range(0, 1));
      s_axis_tcp_rx_tdata = d;
      s_axis_tcp_rx_tkeep = k;
      s_axis_tcp_rx_tlast = (i == tl_pos);
      #1;
      chk("s_tready_mirror", s_axis_tcp_rx_tready, m_axis_rx_u_tready);
      chk("m_tvalid", m_axis_rx_u_tvalid, s_axis_tcp_rx_tvalid);
      chk("m_tlast", m_axis_rx_u_tlast, s_axis_tcp_rx_tvalid && i == beats - 1);
      chk("ntf_ready_busy", s_tcp_notify_ready, 0);
      if (s_axis_tcp_rx_tvalid && m_axis_rx_u_tready) begin
        chk("m_tdata", m_axis_rx_u_tdata, d);
        chk("m_tkeep", m_axis_rx_u_tkeep, k);
        i++;
        exp_beats++;
        if (i == beats) exp_xfers++;
        rnd(d, k);
      end
      cyc++;
      nx;
    end
    if (i < stop_after) chk("data_timeout_beats", i, stop_after);
  endtask

  task automatic xfer(input logic [15:0] sid, input logic [15:0] len, input logic [15:0] msid,
                      input int tl_pos, input int mode);
    int b;
    b = (int'(len) + 63) / 64;
    start_xfer(sid, len, msid);
    data_phase(b, b, tl_pos, mode);
    s_axis_tcp_rx_tvalid = 1'b1;
    m_axis_rx_u_tready = 1'b1;
    #1;
    chk("post_m_tvalid", m_axis_rx_u_tvalid, 0);
    chk("post_s_tready", s_axis_tcp_rx_tready, 0);
    chk("post_ntf_ready", s_tcp_notify_ready, 1);
    chk("post_sid_err", sid_err, exp_err);
  endtask

  initial begin
    areset = 1'b1;
    s_tcp_notify_valid = 1'b0;
    s_tcp_notify_sid = '0;
    s_tcp_notify_len = '0;
    s_tcp_notify_ip = '0;
    s_tcp_notify_port = '0;
    s_tcp_notify_closed = 1'b0;
    m_tcp_rd_pkg_ready = 1'b0;
    s_tcp_rx_meta_valid = 1'b0;
    s_tcp_rx_meta_sid = '0;
    s_axis_tcp_rx_tvalid = 1'b0;
    s_axis_tcp_rx_tdata = '0;
    s_axis_tcp_rx_tkeep = '0;
    s_axis_tcp_rx_tlast = 1'b0;
    m_axis_rx_u_tready = 1'b0;
    m_rx_req_u_ready = 1'b0;
    #1;
    chk("rst_ntf_ready", s_tcp_notify_ready, 0);
    chk("rst_rd_valid", m_tcp_rd_pkg_valid, 0);
    chk("rst_desc_valid", m_rx_req_u_valid, 0);
    chk("rst_m_tvalid", m_axis_rx_u_tvalid, 0);
    chk("rst_sid_err", sid_err, 0);
    nx;
    nx;
    areset = 1'b0;
    #1;
    chk("idle_ntf_ready", s_tcp_notify_ready, 1);
    xfer(16'd5, 16'd128, 16'd5, -1, 0);
    xfer(16'd7, 16'd65, 16'd7, 0, 0);
    nx;
    s_tcp_notify_valid = 1'b1;
    s_tcp_notify_closed = 1'b1;
    s_tcp_notify_len = 16'd100;
    #1;
    chk("drop_closed_ready", s_tcp_notify_ready, 1);
    nx;
    s_tcp_notify_closed = 1'b0;
    s_tcp_notify_len = 16'd0;
    #1;
    chk("drop_len0_ready", s_tcp_notify_ready, 1);
    chk("drop_closed_no_rd", m_tcp_rd_pkg_valid, 0);
    nx;
    s_tcp_notify_valid = 1'b0;
    exp_drops += 2;
    #1;
    chk("drop_len0_no_rd", m_tcp_rd_pkg_valid, 0);
    chk("drop_still_idle", s_tcp_notify_ready, 1);
    xfer(16'd11, 16'd64, 16'd11, 0, 0);
    xfer(16'd12, 16'd65535, 16'd12, -1, 0);
    xfer(16'd3, 16'd100, 16'd9, -1, 0);
    xfer(16'd4, 16'd50, 16'd4, -1, 2);
    xfer(16'd6, 16'd256, 16'd6, -1, 1);
    for (int t = 0; t < 6; t++) begin
      logic [15:0] sid, len;
      sid = 16'($urandom);
      len = 16'($urandom_range(1, 600));
      xfer(sid, len, ($urandom_range(0, 3) == 0) ? sid ^ 16'h0100 : sid,
           $urandom_range(0, (int'(len) + 63) / 64), 2);
    end
    start_xfer(16'd2, 16'd192, 16'd2);
    data_phase(3, 1, -1, 0);
    s_axis_tcp_rx_tvalid = 1'b1;
    m_axis_rx_u_tready = 1'b1;
    areset = 1'b1;
    exp_err = 1'b0;
    exp_xfers = 0;
    exp_beats = 0;
    exp_drops = 0;
    #1;
    chk("mid_rst_m_tvalid", m_axis_rx_u_tvalid, 0);
    chk("mid_rst_m_tlast", m_axis_rx_u_tlast, 0);
    chk("mid_rst_s_tready", s_axis_tcp_rx_tready, 0);
    chk("mid_rst_ntf_ready", s_tcp_notify_ready, 0);
    chk("mid_rst_sid_err", sid_err, 0);
    nx;
    areset = 1'b0;
    #1;
    chk("after_rst_idle", s_tcp_notify_ready, 1);
    chk("after_rst_m_tvalid", m_axis_rx_u_tvalid, 0);
    chk("after_rst_rd_valid", m_tcp_rd_pkg_valid, 0);
    chk("after_rst_desc_valid", m_rx_req_u_valid, 0);
    xfer(16'd1, 16'd64, 16'd1, -1, 0);
`ifdef TCP_RX_STATS_EN
    chk("stat_xfers", stat_xfers, exp_xfers);
    chk("stat_beats", stat_beats, exp_beats);
    chk("stat_drops", stat_drops, exp_drops);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
